fifo_burst_reader: RTL and testbench
====================================

# fifo_burst_reader

Read-side consumer for the dual-clock byte FIFO: runs entirely in the FIFO's read-clock domain, waits until the FIFO holds a full burst, then drains exactly one burst. Bytes are packed four at a time into 32-bit words and presented on a valid/ready stream. It keeps a running count of completed bursts and a sticky underflow flag for debug.

## Interface
- BURST_LEN, 16: bytes per burst; multiple of 4, range 4..64
- DATA_W, 8: FIFO data width (fixed at 8)
- CNT_W, 7: width of the FIFO read-side occupancy count
- sys_clk  in  1  FIFO read clock; all logic on rising edge
- sys_rst_n  in  1  asynchronous, active-low reset
- fifo_rd_data  in  8  FIFO output byte; valid the cycle after fifo_rd_en (standard read mode, 1-cycle latency)
- fifo_empty  in  1  FIFO empty flag
- fifo_rd_data_count  in  CNT_W  FIFO read-side occupancy
- fifo_rd_en  out  1  FIFO read strobe
- out_data  out  32  packed word; first byte of the group in [31:24], last byte in [7:0]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts the word
- out_last  out  1  high with the final word of a burst
- burst_cnt  out  16  completed bursts; wraps 0xFFFF -> 0
- err_underflow  out  1  sticky; set when a read was due while fifo_empty=1

## Operation
- FSM states: IDLE, READ, CAPT, SEND.
- IDLE: go to READ when fifo_rd_data_count >= BURST_LEN and fifo_empty=0. Load words_left = BURST_LEN/4 and beat = 0.
- READ: fifo_rd_en = (state==READ) && !fifo_empty. This is combinational from state and flag. Each asserted cycle increments beat. After beat 3 is issued, go to CAPT.
- fifo_empty=1 in READ: fifo_rd_en stays 0, beat holds, err_underflow is set. Stay in READ until the flag clears.
- Capture: rd_en_d is fifo_rd_en registered. On every cycle with rd_en_d=1, shift fifo_rd_data into the packer, MSB-first.
- CAPT: wait until 4 bytes are captured; normally 1 cycle. Then go to SEND.
- SEND: out_valid=1. out_data and out_last are held stable until out_ready=1.
- On acceptance (out_valid && out_ready), decrement words_left. If words_left was 1, increment burst_cnt and go to IDLE. Otherwise go to READ with beat = 0.
- out_last = (state==SEND) && words_left==1.
- err_underflow is cleared only by reset.

## Timing
- Reset values: fifo_rd_en=0, out_valid=0, out_data=0, out_last=0, burst_cnt=0, err_underflow=0. FSM goes to IDLE.
- Reset mid-burst discards any partial word and the remaining bytes.
- Trigger seen in cycle 0 (IDLE): fifo_rd_en is high in cycles 1–4 and bytes are captured on the edges ending cycles 2–5. CAPT occupies cycle 5 and out_valid is first high in cycle 6.
- With out_ready tied high, each word takes 6 cycles. A 16-byte burst takes 24 cycles from the first READ to the return to IDLE.
- IDLE re-evaluates the trigger in the cycle after the return, so there is a minimum 1 idle cycle between bursts.
- out_ready low in SEND stalls the block indefinitely with no FIFO reads. Bytes beyond the current word stay in the FIFO.
- The FIFO never receives a read while empty.

## Structure
- Package fifo_rd_pkg holds:
  - state enum (IDLE, READ, CAPT, SEND)
  - BYTES_PER_WORD = 4
  - burst_cnt width constant
- Sub-module byte_packer contains the 4-byte MSB-first shift register and its captured-count. Its interface is shift_en, byte_in, word_out and full.

## Test plan
- Trigger threshold: preload 15 bytes 0x00..0x0E -> no fifo_rd_en; add 0x0F -> fifo_rd_en in 4 consecutive cycles starting 1 cycle after count=16.
- Packing and order: bytes 0x00..0x0F with out_ready=1 -> words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F. out_last only on the 4th word; burst_cnt=1; 24-cycle span.
- Backpressure: hold out_ready=0 for 10 cycles on word 2 -> out_data stable at 0x04050607 and no fifo_rd_en during the stall; resumes correctly afterwards.
- Underflow: force fifo_empty=1 for 3 cycles mid-READ -> fifo_rd_en=0 during that window, err_underflow=1 and sticky, words still correct after recovery.
- Reset mid-burst: assert sys_rst_n=0 during CAPT of word 2 -> all outputs 0 immediately. After release, the next full burst packs cleanly from its first byte.
- Counter wrap: preset burst_cnt to 0xFFFF via a forced bench value, complete one burst -> burst_cnt=0x0000.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
//==============================================================================
// Module : fifo_rd_pkg
// Shared types and constants for the FIFO burst reader.
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

package fifo_rd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        CAPT = 2'd2,
        SEND = 2'd3
    } rd_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int BURST_CNT_W    = 16;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
//==============================================================================
// Module : byte_packer
// Four-byte MSB-first shift register with a captured-byte count.
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module byte_packer
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             shift_en,
    input  logic [DATA_W-1:0]                byte_in,
    output logic [BYTES_PER_WORD*DATA_W-1:0] word_out,
    output logic                             full
);

    localparam int CNT_W = $clog2(BYTES_PER_WORD + 1);

    logic [BYTES_PER_WORD*DATA_W-1:0] r_word;
    logic [CNT_W-1:0]                 r_cnt;

    // The first shift after a completed word restarts the count, so no
    // explicit clear is needed between words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (shift_en) begin
            r_word <= {r_word[(BYTES_PER_WORD-1)*DATA_W-1:0], byte_in};
            r_cnt  <= full ? CNT_W'(1) : r_cnt + CNT_W'(1);
        end
    end

    assign word_out = r_word;
    assign full     = (r_cnt == CNT_W'(BYTES_PER_WORD));

endmodule

`default_nettype wire

// File: rtl/fifo_burst_reader.sv
//==============================================================================
// Module : fifo_burst_reader
// Drains one burst from a byte FIFO and streams it as packed 32-bit words.
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module fifo_burst_reader
    import fifo_rd_pkg::*;
#(
    parameter int BURST_LEN = 16,
    parameter int DATA_W    = 8,
    parameter int CNT_W     = 7
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst_n,
    input  logic [DATA_W-1:0]      fifo_rd_data,
    input  logic                   fifo_empty,
    input  logic [CNT_W-1:0]       fifo_rd_data_count,
    output logic                   fifo_rd_en,
    output logic [31:0]            out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic [BURST_CNT_W-1:0] burst_cnt,
    output logic                   err_underflow
);

    localparam int WORDS_PER_BURST = BURST_LEN / BYTES_PER_WORD;
    localparam int WL_W            = $clog2(WORDS_PER_BURST + 1);

    rd_state_t               r_state;
    rd_state_t               w_next_state;
    logic [WL_W-1:0]         r_words_left;
    logic [1:0]              r_beat;
    logic                    r_rd_en_d;
    logic [BURST_CNT_W-1:0]  r_burst_cnt;
    logic                    r_err;
    logic                    w_trigger;
    logic                    w_accept;
    logic                    w_full;
    logic [31:0]             w_word;

    assign w_trigger  = (fifo_rd_data_count >= CNT_W'(BURST_LEN)) && !fifo_empty;
    assign fifo_rd_en = (r_state == READ) && !fifo_empty;
    assign w_accept   = (r_state == SEND) && out_ready;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_trigger) w_next_state = READ;
            READ: if (fifo_rd_en && r_beat == 2'd3) w_next_state = CAPT;
            // The last read's byte lands on the edge that ends CAPT.
            CAPT: if (r_rd_en_d || w_full) w_next_state = SEND;
            SEND: if (out_ready)
                      w_next_state = (r_words_left == WL_W'(1)) ? IDLE : READ;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state      <= IDLE;
            r_words_left <= '0;
            r_beat       <= '0;
            r_rd_en_d    <= 1'b0;
            r_burst_cnt  <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_rd_en_d <= fifo_rd_en;
            if (r_state == IDLE) begin
                r_beat <= '0;
                if (w_trigger) r_words_left <= WL_W'(WORDS_PER_BURST);
            end else if (fifo_rd_en) begin
                r_beat <= r_beat + 2'd1;
            end
            if (w_accept) begin
                r_words_left <= r_words_left - WL_W'(1);
                r_beat       <= '0;
                if (r_words_left == WL_W'(1)) r_burst_cnt <= r_burst_cnt + 1'b1;
            end
            if (r_state == READ && fifo_empty) r_err <= 1'b1;
        end
    end

    byte_packer #(
        .DATA_W (DATA_W)
    ) u_packer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .shift_en (r_rd_en_d),
        .byte_in  (fifo_rd_data),
        .word_out (w_word),
        .full     (w_full)
    );

    assign out_data      = w_word;
    assign out_valid     = (r_state == SEND);
    assign out_last      = (r_state == SEND) && (r_words_left == WL_W'(1));
    assign burst_cnt     = r_burst_cnt;
    assign err_underflow = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
//==============================================================================
// Module : tb_fifo_burst_reader
// Self-checking bench: byte FIFO stand-in, word-stream model, directed tests.
// Rev 1.0
//==============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fifo_burst_reader;

    localparam int BURST_LEN = 16;
    localparam int CNT_W     = 7;
    localparam int WPB       = BURST_LEN / 4;

    logic             sys_clk   = 1'b0;
    logic             sys_rst_n = 1'b0;
    logic [7:0]       fifo_rd_data = 8'h00;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_rd_data_count;
    logic             fifo_rd_en;
    logic [31:0]      out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             out_last;
    logic [15:0]      burst_cnt;
    logic             err_underflow;

    fifo_burst_reader #(
        .BURST_LEN (BURST_LEN),
        .DATA_W    (8),
        .CNT_W     (CNT_W)
    ) dut (
        .sys_clk            (sys_clk),
        .sys_rst_n          (sys_rst_n),
        .fifo_rd_data       (fifo_rd_data),
        .fifo_empty         (fifo_empty),
        .fifo_rd_data_count (fifo_rd_data_count),
        .fifo_rd_en         (fifo_rd_en),
        .out_data           (out_data),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_last           (out_last),
        .burst_cnt          (burst_cnt),
        .err_underflow      (err_underflow)
    );

    always #5 sys_clk = ~sys_clk;

    // Byte FIFO stand-in: one-cycle read latency, optional forced-empty flag.
    logic [7:0] mem [0:255];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       force_empty = 1'b0;
    logic       flush = 1'b0;

    assign fifo_empty         = (wr_ptr == rd_ptr) || force_empty;
    assign fifo_rd_data_count = CNT_W'(wr_ptr - rd_ptr);

    always @(posedge sys_clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (fifo_rd_en && wr_ptr != rd_ptr) begin
            fifo_rd_data <= mem[rd_ptr % 256];
            rd_ptr       <= rd_ptr + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: words are the pushed byte stream taken four at a time, and every
    // WPB-th accepted word closes a burst.
    int          exp_ptr   = 0;
    int          word_idx  = 0;
    logic [15:0] model_cnt = 16'h0000;
    logic        exp_err   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    function automatic logic [31:0] model_word(input int p);
        return {mem[p % 256], mem[(p + 1) % 256], mem[(p + 2) % 256], mem[(p + 3) % 256]};
    endfunction

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            model_cnt  = 16'h0000;
            word_idx   = 0;
            exp_ptr    = wr_ptr;
            prev_stall = 1'b0;
        end else begin
            chk("burst_cnt", burst_cnt, model_cnt);
            chk("err_underflow", err_underflow, exp_err);
            chk("rd_en_while_empty", fifo_rd_en & fifo_empty, 0);
            if (out_valid) chk("rd_en_during_send", fifo_rd_en, 0);
            if (!out_valid) chk("last_without_valid", out_last, 0);
            if (prev_stall) begin
                chk("stall_valid", out_valid, 1);
                chk("stall_data", out_data, prev_data);
                chk("stall_last", out_last, prev_last);
            end
            if (out_valid && out_ready) begin
                chk("word", out_data, model_word(exp_ptr));
                chk("word_last", out_last, (word_idx == WPB - 1));
                exp_ptr += 4;
                if (word_idx == WPB - 1) begin
                    word_idx  = 0;
                    model_cnt = model_cnt + 16'h1;
                end else begin
                    word_idx++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 256] = b;
        wr_ptr++;
    endtask

    task automatic push_burst(input logic [7:0] base);
        for (int i = 0; i < BURST_LEN; i++) push(base + 8'(i));
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        @(negedge sys_clk);
        while (!out_valid && n < 100) begin
            @(negedge sys_clk);
            n++;
        end
        chk(tag, out_valid, 1);
    endtask

    task automatic wait_burst_cnt(input logic [15:0] target);
        int n = 0;
        while (burst_cnt != target && n < 300) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        chk("burst_done", burst_cnt, target);
    endtask

    task automatic wait_reads(input int target);
        int n = 0;
        int seen = 0;
        while (seen < target && n < 300) begin
            @(negedge sys_clk);
            if (fifo_rd_en) seen++;
            n++;
        end
        chk("read_count_reached", seen, target);
    endtask

    logic        rd_hist   [0:30];
    logic        val_hist  [0:30];
    logic        acc_last  [0:30];
    logic [31:0] data_hist [0:30];
    logic [6:0]  exp_rd = 7'b0011110;

    initial begin
        // Reset values
        repeat (2) tick();
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_last", out_last, 0);
        chk("rst_burst_cnt", burst_cnt, 0);
        chk("rst_err", err_underflow, 0);
        sys_rst_n = 1'b1;
        tick();

        // Trigger threshold, packing order, burst timing
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) push(8'(i));
        for (int i = 0; i < 5; i++) begin
            chk("no_rd_below_threshold", fifo_rd_en, 0);
            tick();
        end
        push(8'h0F);
        for (int c = 0; c <= 30; c++) begin
            @(negedge sys_clk);
            rd_hist[c]   = fifo_rd_en;
            val_hist[c]  = out_valid;
            acc_last[c]  = out_valid && out_ready && out_last;
            data_hist[c] = out_data;
        end
        for (int c = 0; c <= 6; c++) chk("trigger_rd_en", rd_hist[c], exp_rd[c]);
        chk("capt_not_valid", val_hist[5], 0);
        chk("first_valid", val_hist[6], 1);
        chk("first_word", data_hist[6], 32'h00010203);
        chk("last_word", data_hist[24], 32'h0C0D0E0F);
        chk("last_cycle", acc_last[24], 1);
        chk("idle_after_burst", val_hist[25] | rd_hist[25], 0);
        chk("burst_cnt_one", burst_cnt, 1);

        // Backpressure on word 2
        tick();
        out_ready = 1'b0;
        push_burst(8'h00);
        wait_valid("bp_word1_valid");
        tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        wait_valid("bp_word2_valid");
        begin
            int stall_rd = 0;
            for (int i = 0; i < 10; i++) begin
                if (i > 0) @(negedge sys_clk);
                if (fifo_rd_en) stall_rd++;
                chk("bp_data", out_data, 32'h04050607);
            end
            chk("bp_no_reads", stall_rd, 0);
        end
        tick();
        out_ready = 1'b1;
        wait_burst_cnt(16'd2);

        // Underflow mid-READ
        tick();
        push_burst(8'h20);
        wait_reads(2);
        tick();
        force_empty = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            chk("uf_rd_en", fifo_rd_en, 0);
            tick();
            if (k == 0) exp_err = 1'b1;
        end
        force_empty = 1'b0;
        wait_burst_cnt(16'd3);
        chk("uf_sticky", err_underflow, 1);

        // Reset during CAPT of word 2
        tick();
        push_burst(8'h30);
        wait_reads(8);
        tick();
        sys_rst_n = 1'b0;
        flush     = 1'b1;
        exp_err   = 1'b0;
        #1;
        chk("rst_mid_rd_en", fifo_rd_en, 0);
        chk("rst_mid_valid", out_valid, 0);
        chk("rst_mid_data", out_data, 0);
        chk("rst_mid_last", out_last, 0);
        chk("rst_mid_cnt", burst_cnt, 0);
        chk("rst_mid_err", err_underflow, 0);
        tick();
        tick();
        sys_rst_n = 1'b1;
        flush     = 1'b0;
        tick();
        push_burst(8'h40);
        wait_valid("post_rst_valid");
        chk("post_rst_word", out_data, 32'h40414243);
        wait_burst_cnt(16'd1);

        // Counter wrap
        tick();
        force dut.r_burst_cnt = 16'hFFFF;
        model_cnt = 16'hFFFF;
        tick();
        release dut.r_burst_cnt;
        tick();
        chk("preset_cnt", burst_cnt, 16'hFFFF);
        push_burst(8'h50);
        wait_burst_cnt(16'h0000);
        chk("wrap_cnt", burst_cnt, 16'h0000);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
